// File: rtl/i2s_audio_tx.sv
// Philips-I2S master transmitter: 2-entry sample FIFO feeding a 64-bit-clock frame serialiser.
// All I2S clocks are derived from clk by an integer divider; nothing runs while enable is low.
module i2s_audio_tx #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 16,
    parameter int MONO     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              b_clk,
    output logic              lr_clk,
    output logic              i2s_out,
    output logic              frame_start,
    output logic              underrun
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        k;
    logic [5:0]        pos;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic [1:0]        pop_n;
    logic [DATA_W-1:0] fifo0;
    logic [DATA_W-1:0] fifo1;
    logic [DATA_W-1:0] fifo0_nxt;
    logic [DATA_W-1:0] fifo1_nxt;
    logic [DATA_W-1:0] l_word;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] chan_word;
    logic              push;
    logic              div_wrap;
    logic              fall;
    logic              load;
    logic              starve;

    // Sample is left-justified in a 32-bit slot; bits past DATA_W are zero padding.
    function automatic logic slot_bit(input logic [DATA_W-1:0] word, input logic [4:0] b);
        logic [31:0] slot;
        slot = {word, {(32 - DATA_W){1'b0}}};
        return slot[5'd31 - b];
    endfunction

    assign s_ready   = (count != 2'd2);
    assign push      = s_valid && s_ready;
    assign div_wrap  = enable && (div_cnt == DIV_LAST);
    assign fall      = div_wrap && b_clk;
    assign load      = fall && (k == 6'd0);
    assign starve    = load && (pop_n == 2'd0);
    assign pos       = k - 6'd1;
    assign chan_word = pos[5] ? r_word : l_word;

    always_comb begin
        pop_n = 2'd0;
        if (load) begin
            if (MONO != 0) pop_n = (count != 2'd0) ? 2'd1 : 2'd0;
            else           pop_n = (count == 2'd2) ? 2'd2 : 2'd0;
        end
    end

    // Pop first, then the pushed word lands behind whatever is left.
    always_comb begin
        fifo0_nxt = fifo0;
        fifo1_nxt = fifo1;
        count_nxt = count;
        if (pop_n == 2'd1) begin
            fifo0_nxt = fifo1;
            count_nxt = count - 2'd1;
        end else if (pop_n == 2'd2) begin
            count_nxt = 2'd0;
        end
        if (push) begin
            if (count_nxt == 2'd0) fifo0_nxt = s_data;
            else                   fifo1_nxt = s_data;
            count_nxt = count_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        fifo0 <= fifo0_nxt;
        fifo1 <= fifo1_nxt;
        if (!enable) begin
            l_word <= '0;
            r_word <= '0;
        end else if (load) begin
            if (pop_n == 2'd0) begin
                l_word <= '0;
                r_word <= '0;
            end else begin
                l_word <= fifo0;
                r_word <= (MONO != 0) ? fifo0 : fifo1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            div_cnt     <= '0;
            b_clk       <= 1'b0;
            k           <= 6'd0;
            lr_clk      <= 1'b0;
            i2s_out     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            count       <= count_nxt;
            frame_start <= load;
            underrun    <= starve;
            if (!enable) begin
                div_cnt <= '0;
                b_clk   <= 1'b0;
                k       <= 6'd0;
                lr_clk  <= 1'b0;
                i2s_out <= 1'b0;
            end else begin
                div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                if (div_wrap) b_clk <= ~b_clk;
                // Data and word select change only on b_clk falling edges.
                if (fall) begin
                    k       <= k + 6'd1;
                    lr_clk  <= k[5];
                    i2s_out <= slot_bit(chan_word, pos[4:0]);
                end
            end
        end
    end
endmodule
